// File: rtl/cal_pkg.sv
// Shared calendar definitions: BCD digit type, month-length and month-code
// constants, update-event encoding and the BCD helper functions used by the
// calendar counter.
// Optional feature macro: CAL_LEAP_EN (February has 29 days in leap years).
package cal_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Month lengths as two-digit BCD values.
  localparam logic [7:0] DAYS_28 = 8'h28;
  localparam logic [7:0] DAYS_29 = 8'h29;
  localparam logic [7:0] DAYS_30 = 8'h30;
  localparam logic [7:0] DAYS_31 = 8'h31;

  // Month codes the update logic needs to recognise.
  localparam logic [7:0] MONTH_JAN = 8'h01;
  localparam logic [7:0] MONTH_FEB = 8'h02;
  localparam logic [7:0] MONTH_DEC = 8'h12;

  localparam logic [7:0] DAY_FIRST = 8'h01;

  // One update per cycle; the highest-priority event wins.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_PULSE_DAY,
    EV_YEAR_ADD,
    EV_MONTH_ADD,
    EV_DAY_ADD
  } cal_event_t;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] value);
    bcd_digit_t ones;
    bcd_digit_t tens;
    ones = value[3:0];
    tens = value[7:4];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Four-digit BCD year increment; the century digits never change, so
  // 2099 wraps back to 2000.
  function automatic logic [15:0] year_inc(input logic [15:0] year);
    return {year[15:8], bcd2_inc(year[7:0])};
  endfunction

`ifdef CAL_LEAP_EN
  // Low two BCD digits divisible by four: 10*t + o = 4k  <=>  2*t + o = 4k,
  // so even tens need ones in {0,4,8} and odd tens need ones in {2,6}.
  function automatic logic is_leap(input logic [15:0] year);
    bcd_digit_t ones;
    ones = year[3:0];
    if (year[4] == 1'b0) begin
      return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    end else begin
      return (ones == 4'd2) || (ones == 4'd6);
    end
  endfunction
`endif

  // Number of days in a BCD month; leap selects the long February.
  function automatic logic [7:0] month_length(input logic [7:0] month,
                                              input logic       leap);
    logic [7:0] len;
    case (month)
      MONTH_FEB: len = leap ? DAYS_29 : DAYS_28;
      8'h04, 8'h06, 8'h09, 8'h11: len = DAYS_30;
      default: len = DAYS_31;
    endcase
    return len;
  endfunction

  // Pull a day back to the last day of the month if it overshoots.
  function automatic logic [7:0] clamp_day(input logic [7:0] day,
                                           input logic [7:0] len);
    return (day > len) ? len : day;
  endfunction

endpackage

// File: rtl/cal_edge_det.sv
// Registers one input and flags its rising edge. The flag is valid in the
// cycle after the input was first sampled high, so a held level yields a
// single event.
module cal_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sampled;
  logic sampled_prev;

  // Sample the input and keep the previous sample for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampled      <= 1'b0;
      sampled_prev <= 1'b0;
    end else begin
      sampled      <= din;
      sampled_prev <= sampled;
    end
  end

  assign rise = sampled & ~sampled_prev;

endmodule

// File: rtl/calendar_counter.sv
// BCD calendar (year/month/day) advanced by a day-rollover strobe and by
// three manual advance keys, with a one-cycle new-year pulse.
// Optional feature macro: CAL_LEAP_EN (leap-year February of 29 days).
module calendar_counter
  import cal_pkg::*;
#(
  parameter logic [15:0] YEAR_INIT  = 16'h2000,
  parameter logic [7:0]  MONTH_INIT = 8'h01,
  parameter logic [7:0]  DAY_INIT   = 8'h01
) (
  input  logic        CLK_50,
  input  logic        CR,
  input  logic        pulse_day,
  input  logic        day_add,
  input  logic        month_add,
  input  logic        year_add,
  output logic [15:0] Year,
  output logic [7:0]  Month,
  output logic [7:0]  Day,
  output logic        new_year
);

  logic pulse_day_rise;
  logic day_add_rise;
  logic month_add_rise;
  logic year_add_rise;

  cal_edge_det u_pulse_day_det (
    .clk  (CLK_50),
    .rst  (CR),
    .din  (pulse_day),
    .rise (pulse_day_rise)
  );

  cal_edge_det u_day_add_det (
    .clk  (CLK_50),
    .rst  (CR),
    .din  (day_add),
    .rise (day_add_rise)
  );

  cal_edge_det u_month_add_det (
    .clk  (CLK_50),
    .rst  (CR),
    .din  (month_add),
    .rise (month_add_rise)
  );

  cal_edge_det u_year_add_det (
    .clk  (CLK_50),
    .rst  (CR),
    .din  (year_add),
    .rise (year_add_rise)
  );

  cal_event_t cal_ev;

  // Pick the single event to act on this cycle; lower priorities are dropped.
  always_comb begin
    cal_ev = EV_NONE;
    if (pulse_day_rise) begin
      cal_ev = EV_PULSE_DAY;
    end else if (year_add_rise) begin
      cal_ev = EV_YEAR_ADD;
    end else if (month_add_rise) begin
      cal_ev = EV_MONTH_ADD;
    end else if (day_add_rise) begin
      cal_ev = EV_DAY_ADD;
    end
  end

  logic [15:0] year_plus;
  logic [7:0]  month_plus;
  logic [7:0]  day_plus;
  logic        leap_cur;
  logic        leap_next_year;
  logic [7:0]  len_cur;
  logic [7:0]  len_next_month;
  logic [7:0]  len_next_year;

  assign year_plus  = year_inc(Year);
  assign month_plus = (Month == MONTH_DEC) ? MONTH_JAN : bcd2_inc(Month);
  assign day_plus   = bcd2_inc(Day);

`ifdef CAL_LEAP_EN
  assign leap_cur       = is_leap(Year);
  assign leap_next_year = is_leap(year_plus);
`else
  assign leap_cur       = 1'b0;
  assign leap_next_year = 1'b0;
`endif

  // Month length for the current date and for the two candidate dates
  // a month or year key would produce.
  assign len_cur        = month_length(Month, leap_cur);
  assign len_next_month = month_length(month_plus, leap_cur);
  assign len_next_year  = month_length(Month, leap_next_year);

  logic [15:0] year_next;
  logic [7:0]  month_next;
  logic [7:0]  day_next;
  logic        new_year_next;

  // Compute the next date for the selected event; no event holds the date.
  always_comb begin
    year_next     = Year;
    month_next    = Month;
    day_next      = Day;
    new_year_next = 1'b0;
    case (cal_ev)
      EV_PULSE_DAY: begin
        if (Day == len_cur) begin
          day_next   = DAY_FIRST;
          month_next = month_plus;
          if (Month == MONTH_DEC) begin
            year_next     = year_plus;
            new_year_next = 1'b1;
          end
        end else begin
          day_next = day_plus;
        end
      end
      EV_YEAR_ADD: begin
        year_next = year_plus;
        day_next  = clamp_day(Day, len_next_year);
      end
      EV_MONTH_ADD: begin
        month_next = month_plus;
        day_next   = clamp_day(Day, len_next_month);
      end
      EV_DAY_ADD: begin
        day_next = (Day == len_cur) ? DAY_FIRST : day_plus;
      end
      default: begin
        day_next = Day;
      end
    endcase
  end

  // Date and new-year registers; reset discards any pending update.
  always_ff @(posedge CLK_50 or posedge CR) begin
    if (CR) begin
      Year     <= YEAR_INIT;
      Month    <= MONTH_INIT;
      Day      <= DAY_INIT;
      new_year <= 1'b0;
    end else begin
      Year     <= year_next;
      Month    <= month_next;
      Day      <= day_next;
      new_year <= new_year_next;
    end
  end

endmodule

// File: tb/tb_calendar_counter.sv
// Directed bench for calendar_counter with default INIT parameters.
// Expected February behaviour follows CAL_LEAP_EN when it is defined.
module tb_calendar_counter;

  logic        CLK_50;
  logic        CR;
  logic        pulse_day;
  logic        day_add;
  logic        month_add;
  logic        year_add;
  logic [15:0] Year;
  logic [7:0]  Month;
  logic [7:0]  Day;
  logic        new_year;

  int vectors;
  int miscompares;

`ifdef CAL_LEAP_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  calendar_counter dut (
    .CLK_50    (CLK_50),
    .CR        (CR),
    .pulse_day (pulse_day),
    .day_add   (day_add),
    .month_add (month_add),
    .year_add  (year_add),
    .Year      (Year),
    .Month     (Month),
    .Day       (Day),
    .new_year  (new_year)
  );

  // 50 MHz clock.
  initial begin
    CLK_50 = 1'b0;
    forever #10 CLK_50 = ~CLK_50;
  end

  // 0=pulse_day 1=day_add 2=month_add 3=year_add
  task automatic drive_key(input int sel, input logic val);
    case (sel)
      0: pulse_day = val;
      1: day_add   = val;
      2: month_add = val;
      default: year_add = val;
    endcase
  endtask

  // One-cycle key press; returns at the negedge after the update landed.
  task automatic press(input int sel);
    @(negedge CLK_50);
    drive_key(sel, 1'b1);
    @(negedge CLK_50);
    drive_key(sel, 1'b0);
    @(negedge CLK_50);
  endtask

  task automatic do_reset();
    @(negedge CLK_50);
    CR = 1'b1;
    pulse_day = 1'b0;
    day_add = 1'b0;
    month_add = 1'b0;
    year_add = 1'b0;
    repeat (2) @(negedge CLK_50);
    CR = 1'b0;
    @(negedge CLK_50);
  endtask

  // Starting from 2000/01/01, advance to 20yy/mm/dd with the manual keys.
  task automatic set_date(input int yy, input int mm, input int dd);
    do_reset();
    for (int i = 0; i < yy; i++) press(3);
    for (int i = 1; i < mm; i++) press(2);
    for (int i = 1; i < dd; i++) press(1);
  endtask

  task automatic test_reset();
    @(negedge CLK_50);
    CR = 1'b1;
    pulse_day = 1'b0;
    day_add = 1'b0;
    month_add = 1'b0;
    year_add = 1'b0;
    #1;
    vectors++;
    if ({Year, Month, Day} !== 32'h20000101) begin
      miscompares++;
      $display("[TB] FAIL reset_date: got %h expected %h", {Year, Month, Day}, 32'h20000101);
    end
    vectors++;
    if (new_year !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_new_year: got %b expected 0", new_year);
    end
    repeat (2) @(negedge CLK_50);
    CR = 1'b0;
    @(negedge CLK_50);
  endtask

  task automatic test_pulse_latency();
    pulse_day = 1'b1;
    @(negedge CLK_50);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000101) begin
      miscompares++;
      $display("[TB] FAIL latency_early: got %h expected %h", {Year, Month, Day}, 32'h20000101);
    end
    pulse_day = 1'b0;
    @(negedge CLK_50);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000102) begin
      miscompares++;
      $display("[TB] FAIL latency_update: got %h expected %h", {Year, Month, Day}, 32'h20000102);
    end
  endtask

  task automatic test_new_year();
    set_date(23, 12, 31);
    vectors++;
    if ({Year, Month, Day} !== 32'h20231231) begin
      miscompares++;
      $display("[TB] FAIL preload_2023: got %h expected %h", {Year, Month, Day}, 32'h20231231);
    end
    @(negedge CLK_50);
    pulse_day = 1'b1;
    @(negedge CLK_50);
    pulse_day = 1'b0;
    vectors++;
    if (new_year !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL new_year_early: got %b expected 0", new_year);
    end
    @(negedge CLK_50);
    vectors++;
    if ({Year, Month, Day, new_year} !== {32'h20240101, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL new_year_roll: got %h/%b expected 20240101/1", {Year, Month, Day}, new_year);
    end
    @(negedge CLK_50);
    vectors++;
    if (new_year !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL new_year_width: got %b expected 0", new_year);
    end
  endtask

  task automatic test_leap_february();
    logic [31:0] exp1;
    logic [31:0] exp2;
    exp1 = LEAP ? 32'h20240229 : 32'h20240301;
    exp2 = LEAP ? 32'h20240301 : 32'h20240302;
    set_date(24, 2, 28);
    press(0);
    vectors++;
    if ({Year, Month, Day} !== exp1) begin
      miscompares++;
      $display("[TB] FAIL feb28_pulse: got %h expected %h", {Year, Month, Day}, exp1);
    end
    press(0);
    vectors++;
    if ({Year, Month, Day} !== exp2) begin
      miscompares++;
      $display("[TB] FAIL feb_second_pulse: got %h expected %h", {Year, Month, Day}, exp2);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] exp1;
    exp1 = LEAP ? 32'h20240229 : 32'h20240228;
    set_date(24, 1, 31);
    press(2);
    vectors++;
    if ({Year, Month, Day} !== exp1) begin
      miscompares++;
      $display("[TB] FAIL month_clamp_feb: got %h expected %h", {Year, Month, Day}, exp1);
    end
    press(3);
    vectors++;
    if ({Year, Month, Day} !== 32'h20250228) begin
      miscompares++;
      $display("[TB] FAIL year_clamp_feb: got %h expected %h", {Year, Month, Day}, 32'h20250228);
    end
    press(1);
    vectors++;
    if ({Year, Month, Day} !== 32'h20250201) begin
      miscompares++;
      $display("[TB] FAIL day_add_wrap: got %h expected %h", {Year, Month, Day}, 32'h20250201);
    end
    set_date(0, 3, 31);
    press(2);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000430) begin
      miscompares++;
      $display("[TB] FAIL month_clamp_apr: got %h expected %h", {Year, Month, Day}, 32'h20000430);
    end
    set_date(0, 12, 31);
    press(2);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000131) begin
      miscompares++;
      $display("[TB] FAIL month_wrap_dec: got %h expected %h", {Year, Month, Day}, 32'h20000131);
    end
  endtask

  task automatic test_priority_and_hold();
    set_date(0, 5, 10);
    @(negedge CLK_50);
    pulse_day = 1'b1;
    day_add = 1'b1;
    @(negedge CLK_50);
    pulse_day = 1'b0;
    day_add = 1'b0;
    @(negedge CLK_50);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000511) begin
      miscompares++;
      $display("[TB] FAIL pulse_over_day: got %h expected %h", {Year, Month, Day}, 32'h20000511);
    end
    @(negedge CLK_50);
    year_add = 1'b1;
    month_add = 1'b1;
    @(negedge CLK_50);
    year_add = 1'b0;
    month_add = 1'b0;
    @(negedge CLK_50);
    vectors++;
    if ({Year, Month, Day} !== 32'h20010511) begin
      miscompares++;
      $display("[TB] FAIL year_over_month: got %h expected %h", {Year, Month, Day}, 32'h20010511);
    end
    day_add = 1'b1;
    repeat (100) @(negedge CLK_50);
    day_add = 1'b0;
    repeat (2) @(negedge CLK_50);
    vectors++;
    if ({Year, Month, Day} !== 32'h20010512) begin
      miscompares++;
      $display("[TB] FAIL held_day_add: got %h expected %h", {Year, Month, Day}, 32'h20010512);
    end
  endtask

  task automatic test_year_wrap();
    set_date(99, 12, 31);
    press(0);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000101) begin
      miscompares++;
      $display("[TB] FAIL wrap_2099_pulse: got %h expected %h", {Year, Month, Day}, 32'h20000101);
    end
    set_date(99, 6, 15);
    press(3);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000615) begin
      miscompares++;
      $display("[TB] FAIL wrap_2099_key: got %h expected %h", {Year, Month, Day}, 32'h20000615);
    end
  endtask

  task automatic test_mid_reset();
    set_date(0, 1, 5);
    @(negedge CLK_50);
    day_add = 1'b1;
    @(negedge CLK_50);
    CR = 1'b1;
    day_add = 1'b0;
    #1;
    vectors++;
    if ({Year, Month, Day, new_year} !== {32'h20000101, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_async: got %h/%b expected 20000101/0", {Year, Month, Day}, new_year);
    end
    repeat (2) @(negedge CLK_50);
    CR = 1'b0;
    repeat (3) @(negedge CLK_50);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000101) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_discard: got %h expected %h", {Year, Month, Day}, 32'h20000101);
    end
    press(1);
    vectors++;
    if ({Year, Month, Day} !== 32'h20000102) begin
      miscompares++;
      $display("[TB] FAIL after_reset_event: got %h expected %h", {Year, Month, Day}, 32'h20000102);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    CR = 1'b1;
    pulse_day = 1'b0;
    day_add = 1'b0;
    month_add = 1'b0;
    year_add = 1'b0;
    test_reset();
    test_pulse_latency();
    test_new_year();
    test_leap_february();
    test_clamp();
    test_priority_and_hold();
    test_year_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
